// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port RAM arbiter.
package mem_arb_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 9;

  // Requester ids, also used as the grant/owner encoding.
  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } state_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Two-way request selector.
// Default: fixed priority, B over A.
// With MEM_ARB_RR_EN: round robin, so on contention the port that did not win
// last time is picked.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic a_req,
  input  logic b_req,
`ifdef MEM_ARB_RR_EN
  input  logic last_grant,
`endif
  output logic grant_valid,
  output logic grant_id
);

  // Pick a winner. A single requester always wins outright.
  always_comb begin
    grant_valid = a_req | b_req;
    grant_id    = PORT_A;
    if (a_req && b_req) begin
`ifdef MEM_ARB_RR_EN
      grant_id = ~last_grant;
`else
      grant_id = PORT_B;
`endif
    end else if (b_req) begin
      grant_id = PORT_B;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous RAM (1-cycle registered read) between an
// instruction-fetch port (A) and a load/store port (B).
// Writes finish at the grant edge. Reads return data 2 cycles after the grant,
// as a one-cycle rvalid pulse.
// Optional macro MEM_ARB_RR_EN switches contention handling to round robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ready,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ready,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic              ram_read,
  output logic              ram_write,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  state_t state;
  logic   owner;
  logic   grant_valid;
  logic   grant_id;
  logic   gnt;
  logic   win_we;

`ifdef MEM_ARB_RR_EN
  logic   last_grant;
`endif

  mem_arb_pick u_pick (
    .a_req       (a_req),
    .b_req       (b_req),
`ifdef MEM_ARB_RR_EN
    .last_grant  (last_grant),
`endif
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  // Grants are only issued in IDLE; RD_WAIT holds everyone off.
  assign gnt    = (state == IDLE) && grant_valid;
  assign win_we = (grant_id == PORT_B) ? b_we : a_we;

  // Ready handshake and RAM strobes; everything is zero outside a grant cycle.
  always_comb begin
    a_ready   = 1'b0;
    b_ready   = 1'b0;
    ram_read  = 1'b0;
    ram_write = 1'b0;
    ram_addr  = '0;
    ram_din   = '0;
    if (gnt) begin
      a_ready   = (grant_id == PORT_A);
      b_ready   = (grant_id == PORT_B);
      ram_write = win_we;
      ram_read  = ~win_we;
      ram_addr  = (grant_id == PORT_B) ? b_addr  : a_addr;
      ram_din   = (grant_id == PORT_B) ? b_wdata : a_wdata;
    end
  end

  // FSM: IDLE -> RD_WAIT on a read grant.
  // The RD_WAIT exit edge lands ram_dout in the owner's rdata and pulses its
  // rvalid.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      owner    <= PORT_B;
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      a_rdata  <= '0;
      b_rdata  <= '0;
    end else begin
      a_rvalid <= 1'b0;
      b_rvalid <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt && !win_we) begin
            owner <= grant_id;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          state <= IDLE;
          if (owner == PORT_B) begin
            b_rdata  <= ram_dout;
            b_rvalid <= 1'b1;
          end else begin
            a_rdata  <= ram_dout;
            a_rvalid <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MEM_ARB_RR_EN
  // Remember the most recent winner so contention alternates.
  always_ff @(posedge clock or posedge reset) begin
    if (reset)    last_grant <= PORT_A;
    else if (gnt) last_grant <= grant_id;
  end
`endif

endmodule
